conv_window_fetch: RTL and testbench
====================================

// Module: conv_window_fetch
// PURPOSE
//  Upstream read engine for feature_bram: walks a stored IMG_W x IMG_H 8-bit feature map
//  and assembles 3x3 valid-convolution windows (no padding) in raster order.
//  Drives the BRAM read address; the BRAM returns data one clock later.
//  Each 72-bit window goes out on a valid/ready port to the convolution MAC array.
// PARAMETERS
//  IMG_W   64  feature map width in pixels (>=3)
//  IMG_H   64  feature map height in pixels (>=3)
//  ADDR_W  12  BRAM address width
//  DATA_W  8   pixel width
// PORTS
//  clk           in   1          clock, all logic on rising edge
//  reset         in   1          asynchronous, active-low reset (0 = reset)
//  start         in   1          pulse: begin a map scan; ignored unless idle
//  base_addr     in   ADDR_W     BRAM address of pixel (0,0); sampled on accepted start
//  bram_rd_addr  out  ADDR_W     read address to feature_bram
//  bram_rd_data  in   DATA_W     feature_bram data_out (1-cycle read latency)
//  win_data      out  9*DATA_W   window; pixel k=r*3+c at [DATA_W*k +: DATA_W]
//  win_valid     out  1          window on win_data is complete
//  win_ready     in   1          consumer accepts window
//  win_row       out  16         output row index of the current window
//  win_col       out  16         output column index of the current window
//  busy          out  1          scan in progress
//  done          out  1          1-cycle pulse after the final window is accepted
// BEHAVIOUR
//  Reset (reset=0, async): state IDLE. All outputs 0: bram_rd_addr, win_data, win_valid,
//   win_row, win_col, busy, done. Internal counters are cleared. A mid-scan reset aborts
//   the scan with no done pulse.
//  FSM states: IDLE, FETCH, DRAIN, VALID.
//   IDLE : start=1 -> latch base_addr. Set row=col=0, k=0. Go to FETCH and set busy=1.
//   FETCH: every cycle, drive bram_rd_addr = base + (row+k/3)*IMG_W + col + k%3.
//          This sum is computed mod 2^ADDR_W, so the address wraps.
//          Capture bram_rd_data into slot k-1 when k>0, then k++.
//          After issuing k=8, go to DRAIN.
//   DRAIN: capture slot 8. Go to VALID and set win_valid=1.
//   VALID: win_data, win_row and win_col stay stable while win_valid=1 and win_ready=0.
//          On win_valid & win_ready:
//            - deassert win_valid;
//            - advance the window position: col++, and when col=IMG_W-3, col=0 and row++;
//            - if the accepted window was the last (row=IMG_H-3, col=IMG_W-3): go to IDLE,
//              busy=0, done=1 for exactly one cycle;
//            - otherwise set k=0 and go to FETCH.
//  win_ready is ignored outside VALID. There is no combinational path from win_ready to
//   any output.
//  Latency: the first bram_rd_addr is driven the cycle after start. win_valid rises 10
//   cycles after FETCH entry (9 issue cycles + 1 drain cycle).
//   With win_ready=1 throughout, one window completes every 11 cycles.
//  Window count: (IMG_W-2)*(IMG_H-2).
//   win_row range is 0..IMG_H-3; win_col range is 0..IMG_W-3.
//  start while busy: ignored; the current scan is unaffected.
//   start in the same cycle as done: accepted, since the FSM is already IDLE by then.
//  bram_rd_addr holds its last value while in DRAIN, VALID and IDLE.
// TESTING (BRAM model: mem[a] = a[7:0], 1-cycle read latency)
//  1. IMG_W=IMG_H=4, base=0, ready=1:
//     4 windows; window0 = {0,1,2,4,5,6,8,9,10} (k=0..8).
//     window3 = {5,6,7,9,10,11,13,14,15}; done pulses once; busy then drops.
//  2. Same map, win_ready held 0 for 20 cycles on window1:
//     win_data={1,2,3,5,6,7,9,10,11} is held stable with win_valid=1.
//     No new bram_rd_addr activity until accept.
//  3. IMG_W=IMG_H=4, base=4094:
//     window0 addresses are 4094,4095,0,2,3,4,6,7,8, showing address wrap mod 4096.
//  4. start pulsed again while busy (during FETCH of window2):
//     the scan completes with exactly 4 windows and a single done pulse.
//  5. reset=0 asserted during VALID:
//     all outputs go to 0 immediately; no done pulse.
//     After release, a new start gives window0 = {0,1,2,4,5,6,8,9,10}.
//  6. Default 64x64 map, ready=1: 3844 windows.
//     Last window: win_row=61, win_col=61, data base at address 61*64+61=3965.

Source files
------------

// File: rtl/conv_window_fetch.sv
// conv_window_fetch: scans a feature map held in feature_bram and emits 3x3
// valid-convolution windows in raster order over a valid/ready handshake.
// The BRAM has a one-cycle read latency, so each pixel is captured one cycle
// after its address is issued, and one extra DRAIN cycle collects the last one.
//
// state   | meaning
// IDLE    | waiting for start
// FETCH   | issuing the 9 window addresses (k = 0..8), capturing slot k-1
// DRAIN   | capturing slot 8 from the final read
// VALID   | window presented, waiting for the consumer to accept it
module conv_window_fetch #(
  parameter int IMG_W  = 64,
  parameter int IMG_H  = 64,
  parameter int ADDR_W = 12,
  parameter int DATA_W = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [ADDR_W-1:0]   base_addr,
  output logic [ADDR_W-1:0]   bram_rd_addr,
  input  logic [DATA_W-1:0]   bram_rd_data,
  output logic [9*DATA_W-1:0] win_data,
  output logic                win_valid,
  input  logic                win_ready,
  output logic [15:0]         win_row,
  output logic [15:0]         win_col,
  output logic                busy,
  output logic                done
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_VALID} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W-1:0]   addr_calc;
  logic [15:0]         row_q, row_d;
  logic [15:0]         col_q, col_d;
  logic [3:0]          k_q, k_d;
  logic [1:0]          k_r, k_c;
  logic [9*DATA_W-1:0] win_q, win_d;
  logic                done_q, done_d;
  logic                cap;
  logic [3:0]          slot;
  logic                last_col, last_row;

  // Split the window pixel index k into its row/column offset inside the 3x3 window.
  always_comb begin
    k_r = 2'd0;
    k_c = 2'd0;
    case (k_q)
      4'd1: k_c = 2'd1;
      4'd2: k_c = 2'd2;
      4'd3: k_r = 2'd1;
      4'd4: begin k_r = 2'd1; k_c = 2'd1; end
      4'd5: begin k_r = 2'd1; k_c = 2'd2; end
      4'd6: k_r = 2'd2;
      4'd7: begin k_r = 2'd2; k_c = 2'd1; end
      4'd8: begin k_r = 2'd2; k_c = 2'd2; end
      default: ;
    endcase
  end

  // Address arithmetic is deliberately truncated to ADDR_W so a map near the top of
  // the BRAM wraps around to address 0.
  assign addr_calc = base_q
                   + ADDR_W'((32'(row_q) + 32'(k_r)) * IMG_W)
                   + ADDR_W'(32'(col_q) + 32'(k_c));

  assign last_col = (col_q == 16'(IMG_W - 3));
  assign last_row = (row_q == 16'(IMG_H - 3));

  // Next-state, window position and pixel capture.
  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    addr_d  = addr_q;
    row_d   = row_q;
    col_d   = col_q;
    k_d     = k_q;
    win_d   = win_q;
    done_d  = 1'b0;
    cap     = 1'b0;
    slot    = k_q - 4'd1;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          base_d  = base_addr;
          row_d   = 16'd0;
          col_d   = 16'd0;
          k_d     = 4'd0;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        addr_d = addr_calc;
        cap    = (k_q != 4'd0);
        k_d    = k_q + 4'd1;
        if (k_q == 4'd8) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        cap     = 1'b1;
        slot    = 4'd8;
        state_d = S_VALID;
      end
      S_VALID: begin
        if (win_ready) begin
          if (last_col && last_row) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            k_d     = 4'd0;
            state_d = S_FETCH;
            if (last_col) begin
              col_d = 16'd0;
              row_d = row_q + 16'd1;
            end else begin
              col_d = col_q + 16'd1;
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    for (int i = 0; i < 9; i++) begin
      if (cap && (slot == 4'(i))) win_d[DATA_W*i +: DATA_W] = bram_rd_data;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      base_q  <= '0;
      addr_q  <= '0;
      row_q   <= '0;
      col_q   <= '0;
      k_q     <= '0;
      win_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      addr_q  <= addr_d;
      row_q   <= row_d;
      col_q   <= col_d;
      k_q     <= k_d;
      win_q   <= win_d;
      done_q  <= done_d;
    end
  end

  // The address is live during FETCH and otherwise holds the last issued value.
  assign bram_rd_addr = (state_q == S_FETCH) ? addr_calc : addr_q;
  assign win_data     = win_q;
  assign win_valid    = (state_q == S_VALID);
  assign win_row      = row_q;
  assign win_col      = col_q;
  assign busy         = (state_q != S_IDLE);
  assign done         = done_q;

endmodule

// File: tb/tb_conv_window_fetch.sv
// Testbench for conv_window_fetch: a 4x4 instance for directed/random scans and a
// 64x64 instance for the full-map scan. BRAM models return mem[a] = a[7:0].
module tb_conv_window_fetch;
  localparam int SW = 4;
  localparam int SH = 4;
  localparam int LW = 64;
  localparam int LH = 64;
  localparam int AW = 12;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          s_start = 1'b0;
  logic [AW-1:0] s_base  = '0;
  logic [AW-1:0] s_addr;
  logic [DW-1:0] s_rdata;
  logic [9*DW-1:0] s_wdata;
  logic          s_valid;
  logic          s_ready = 1'b0;
  logic [15:0]   s_row, s_col;
  logic          s_busy, s_done;

  logic          l_start = 1'b0;
  logic [AW-1:0] l_base  = '0;
  logic [AW-1:0] l_addr;
  logic [DW-1:0] l_rdata;
  logic [9*DW-1:0] l_wdata;
  logic          l_valid;
  logic          l_ready = 1'b0;
  logic [15:0]   l_row, l_col;
  logic          l_busy, l_done;

  conv_window_fetch #(.IMG_W(SW), .IMG_H(SH), .ADDR_W(AW), .DATA_W(DW)) dut_s (
    .clk(clk), .reset(rst_n), .start(s_start), .base_addr(s_base),
    .bram_rd_addr(s_addr), .bram_rd_data(s_rdata), .win_data(s_wdata),
    .win_valid(s_valid), .win_ready(s_ready), .win_row(s_row), .win_col(s_col),
    .busy(s_busy), .done(s_done));

  conv_window_fetch #(.IMG_W(LW), .IMG_H(LH), .ADDR_W(AW), .DATA_W(DW)) dut_l (
    .clk(clk), .reset(rst_n), .start(l_start), .base_addr(l_base),
    .bram_rd_addr(l_addr), .bram_rd_data(l_rdata), .win_data(l_wdata),
    .win_valid(l_valid), .win_ready(l_ready), .win_row(l_row), .win_col(l_col),
    .busy(l_busy), .done(l_done));

  always @(posedge clk) begin
    s_rdata <= s_addr[7:0];
    l_rdata <= l_addr[7:0];
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: address of pixel k of the window at (r,c), wrapped to the BRAM size.
  function automatic logic [AW-1:0] waddr(int base, int w, int r, int c, int k);
    int a;
    a = (base + (r + k / 3) * w + c + k % 3) % 4096;
    return AW'(a);
  endfunction

  function automatic logic [71:0] wexp(int base, int w, int r, int c);
    logic [71:0] v;
    logic [AW-1:0] a;
    v = '0;
    for (int k = 0; k < 9; k++) begin
      a = waddr(base, w, r, c, k);
      v[8*k +: 8] = a[7:0];
    end
    return v;
  endfunction

  // One scan of the 4x4 map. mode 0: ready=1 always; mode 1: random ready.
  // stall_w: window index held unaccepted for 20 cycles; restart_w: window index
  // during whose fetch a stray start is pulsed.
  task automatic scan_s(input int base, input int mode, input int stall_w, input int restart_w);
    int widx = 0, er = 0, ec = 0, ndone = 0, stall = 0, post = 0;
    bit pend = 0, seen = 0;
    logic [AW-1:0] held = '0;
    @(negedge clk);
    s_start = 1'b1;
    s_base  = AW'(base);
    s_ready = 1'b1;
    for (int iter = 1; iter < 1000 && post < 6; iter++) begin
      @(negedge clk);
      s_start = 1'b0;
      if (pend) begin
        s_start = 1'b1;
        s_base  = 12'h5A5;
        pend    = 0;
      end
      if (iter <= 9) chk("fetch_addr", s_addr, waddr(base, SW, 0, 0, iter - 1));
      if (s_done) ndone++;
      if (ndone > 0) post++;
      chk("busy", s_busy, (ndone == 0));
      if (s_valid) begin
        if (!seen) begin
          seen = 1;
          if (mode == 0 && stall_w < 0) chk("win_latency", iter, 11 + 11 * widx);
        end
        chk("win_data", s_wdata, wexp(base, SW, er, ec));
        chk("win_row", s_row, er);
        chk("win_col", s_col, ec);
        if (widx == stall_w && stall < 20) begin
          if (stall > 0) chk("stall_addr", s_addr, held);
          held = s_addr;
          stall++;
          s_ready = 1'b0;
        end else if (mode == 1) begin
          s_ready = 1'($urandom_range(0, 1));
        end else begin
          s_ready = 1'b1;
        end
        if (s_ready) begin
          widx++;
          seen = 0;
          if (ec == SW - 3) begin ec = 0; er++; end else ec++;
          if (widx == restart_w) pend = 1;
        end
      end else begin
        s_ready = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
      end
    end
    s_ready = 1'b0;
    chk("win_count", widx, (SW - 2) * (SH - 2));
    chk("done_count", ndone, 1);
  endtask

  initial begin
    int lw, lr, lc, ld, lastr, lastc;
    logic [71:0] lastd;
    bit reached;

    repeat (3) @(negedge clk);
    chk("rst_addr", s_addr, 0);
    chk("rst_data", s_wdata, 0);
    chk("rst_valid", s_valid, 0);
    chk("rst_busy", s_busy, 0);
    chk("rst_done", s_done, 0);
    chk("rst_rowcol", {s_row, s_col}, 0);
    rst_n = 1'b1;

    scan_s(0, 0, -1, -1);      // plain scan, ready always high
    scan_s(0, 0, 1, -1);       // window1 held 20 cycles
    scan_s(0, 0, -1, 2);       // stray start during window2 fetch
    scan_s(4094, 0, -1, -1);   // address wrap
    scan_s(int'($urandom_range(0, 4095)), 1, -1, -1);
    scan_s(int'($urandom_range(0, 4095)), 1, -1, -1);

    // Reset while the last window is presented: outputs clear, no done.
    @(negedge clk);
    s_start = 1'b1;
    s_base  = '0;
    s_ready = 1'b1;
    @(negedge clk);
    s_start = 1'b0;
    reached = 0;
    for (int i = 0; i < 100 && !reached; i++) begin
      if (s_valid && s_row == 16'd1 && s_col == 16'd1) begin
        reached = 1;
        s_ready = 1'b0;
      end else begin
        @(negedge clk);
      end
    end
    chk("t5_reached_last", reached, 1);
    chk("t5_addr_pre", s_addr, 15);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_addr", s_addr, 0);
    chk("t5_data", s_wdata, 0);
    chk("t5_valid", s_valid, 0);
    chk("t5_rowcol", {s_row, s_col}, 0);
    chk("t5_busy", s_busy, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t5_no_done", s_done, 0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    chk("t5_no_done_rel", s_done, 0);
    scan_s(0, 0, -1, -1);

    // Full 64x64 scan.
    lw = 0; lr = 0; lc = 0; ld = 0; lastr = -1; lastc = -1; lastd = '0;
    @(negedge clk);
    l_start = 1'b1;
    l_base  = '0;
    l_ready = 1'b1;
    @(negedge clk);
    l_start = 1'b0;
    for (int i = 0; i < 45000 && ld == 0; i++) begin
      @(negedge clk);
      if (l_done) ld++;
      if (l_valid) begin
        chk("big_data", l_wdata, wexp(0, LW, lr, lc));
        lastr = int'(l_row);
        lastc = int'(l_col);
        lastd = l_wdata;
        lw++;
        if (lc == LW - 3) begin lc = 0; lr++; end else lc++;
      end
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (l_done) ld++;
    end
    chk("big_count", lw, (LW - 2) * (LH - 2));
    chk("big_last_row", lastr, 61);
    chk("big_last_col", lastc, 61);
    chk("big_last_data", lastd, wexp(3965, LW, 0, 0));
    chk("big_done", ld, 1);
    chk("big_busy", l_busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
